// File: rtl/tcam_pipelined.sv
// tcam_pipelined: register-based ternary CAM with a two-state write commit FSM and a 2-stage lookup pipeline
//   Ports: CLK/RESET (async, active-high); write side WE, WR_ADDR, DIN, DATA_MASK (1 = don't care),
//   WR_VALID (0 = invalidate), BUSY; lookup side CMP_REQ, CMP_DIN -> MATCH_VALID, MATCH,
//   MATCH_ADDR (lowest hit, zero-extended), MULTIPLE_MATCH (only when TCAM_MULTI_MATCH_EN is defined).
module tcam_pipelined #(
  parameter int C_TCAM_ADDR_WIDTH       = 5,
  parameter int C_TCAM_DATA_WIDTH       = 48,
  parameter int C_TCAM_MATCH_ADDR_WIDTH = 5
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               WE,
  input  logic [C_TCAM_ADDR_WIDTH-1:0]       WR_ADDR,
  input  logic [C_TCAM_DATA_WIDTH-1:0]       DIN,
  input  logic [C_TCAM_DATA_WIDTH-1:0]       DATA_MASK,
  input  logic                               WR_VALID,
  output logic                               BUSY,
  input  logic                               CMP_REQ,
  input  logic [C_TCAM_DATA_WIDTH-1:0]       CMP_DIN,
  output logic                               MATCH_VALID,
  output logic                               MATCH,
`ifdef TCAM_MULTI_MATCH_EN
  output logic                               MULTIPLE_MATCH,
`endif
  output logic [C_TCAM_MATCH_ADDR_WIDTH-1:0] MATCH_ADDR
);
  localparam int DEPTH = 1 << C_TCAM_ADDR_WIDTH;
  typedef enum logic {IDLE, COMMIT} state_t;
  state_t state, state_next;
  logic [C_TCAM_DATA_WIDTH-1:0] key [DEPTH];
  logic [C_TCAM_DATA_WIDTH-1:0] mask [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [C_TCAM_ADDR_WIDTH-1:0] wr_addr_q;
  logic [C_TCAM_DATA_WIDTH-1:0] din_q, mask_q;
  logic wr_valid_q;
  logic [DEPTH-1:0] hit, hit_s1;
  logic req_s1;
  logic [C_TCAM_ADDR_WIDTH-1:0] enc_addr;
  logic enc_any;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_next;
  always_comb state_next = (state == IDLE && WE) ? COMMIT : IDLE;
  always_comb BUSY = (state == COMMIT);
  // WE is only sampled in IDLE, so a strobe during COMMIT never touches the latch
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      wr_addr_q  <= '0;
      din_q      <= '0;
      mask_q     <= '0;
      wr_valid_q <= 1'b0;
    end else if (state == IDLE && WE) begin
      wr_addr_q  <= WR_ADDR;
      din_q      <= DIN;
      mask_q     <= DATA_MASK;
      wr_valid_q <= WR_VALID;
    end
  // Entry updates at the end of COMMIT; a lookup sampled in that same cycle still sees the old entry
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        key[i]  <= '0;
        mask[i] <= '0;
      end
    end else if (state == COMMIT) begin
      valid[wr_addr_q] <= wr_valid_q;
      if (wr_valid_q) begin
        key[wr_addr_q]  <= din_q;
        mask[wr_addr_q] <= mask_q;
      end
    end
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++)
      hit[i] = valid[i] && (((CMP_DIN ^ key[i]) & ~mask[i]) == '0);
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      req_s1 <= 1'b0;
      hit_s1 <= '0;
    end else begin
      req_s1 <= CMP_REQ;
      hit_s1 <= hit;
    end
  // Scan from the top down so the lowest hit is the one left standing
  always_comb begin
    enc_addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (hit_s1[i]) enc_addr = i[C_TCAM_ADDR_WIDTH-1:0];
  end
  always_comb enc_any = |hit_s1;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      MATCH_VALID <= 1'b0;
      MATCH       <= 1'b0;
      MATCH_ADDR  <= '0;
    end else begin
      MATCH_VALID <= req_s1;
      if (req_s1) begin
        MATCH      <= enc_any;
        MATCH_ADDR <= C_TCAM_MATCH_ADDR_WIDTH'(enc_addr);
      end
    end
`ifdef TCAM_MULTI_MATCH_EN
  logic multi, seen;
  // Popcount >= 2 reduces to "a hit after an earlier hit"
  always_comb begin
    multi = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (hit_s1[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) MULTIPLE_MATCH <= 1'b0;
    else if (req_s1) MULTIPLE_MATCH <= multi;
`endif
endmodule

// File: tb/tb_tcam_pipelined.sv
// tb_tcam_pipelined: directed self-checking bench for tcam_pipelined
module tb_tcam_pipelined;
  logic CLK, RESET, WE, WR_VALID, BUSY, CMP_REQ, MATCH_VALID, MATCH;
  logic [4:0] WR_ADDR, MATCH_ADDR;
  logic [47:0] DIN, DATA_MASK, CMP_DIN;
`ifdef TCAM_MULTI_MATCH_EN
  logic MULTIPLE_MATCH;
`endif
  int tests = 0, fails = 0;
  localparam logic [47:0] K3 = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] KM = 48'h112233445566;
  localparam logic [47:0] KX = 48'hDEADBEEF0001;
  localparam logic [47:0] KY = 48'hCAFEF00D0002;
  localparam logic [47:0] KZ = 48'h0000000000AB;
  localparam logic [47:0] KW = 48'h0123456789AB;
  tcam_pipelined dut (
    .CLK(CLK), .RESET(RESET), .WE(WE), .WR_ADDR(WR_ADDR), .DIN(DIN), .DATA_MASK(DATA_MASK),
    .WR_VALID(WR_VALID), .BUSY(BUSY), .CMP_REQ(CMP_REQ), .CMP_DIN(CMP_DIN),
    .MATCH_VALID(MATCH_VALID), .MATCH(MATCH),
`ifdef TCAM_MULTI_MATCH_EN
    .MULTIPLE_MATCH(MULTIPLE_MATCH),
`endif
    .MATCH_ADDR(MATCH_ADDR)
  );
  initial CLK = 0;
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic do_lookup(input logic [47:0] k, output logic v, output logic m, output logic [4:0] a);
    CMP_REQ = 1; CMP_DIN = k;
    tick;
    CMP_REQ = 0;
    tick;
    v = MATCH_VALID; m = MATCH; a = MATCH_ADDR;
  endtask
  task automatic do_write(input logic [4:0] ad, input logic [47:0] k, input logic [47:0] mk, input logic vl, output logic b);
    WE = 1; WR_ADDR = ad; DIN = k; DATA_MASK = mk; WR_VALID = vl;
    tick;
    b = BUSY;
    WE = 0;
    tick;
  endtask
  task automatic test_reset;
    logic v, m; logic [4:0] a;
    RESET = 1;
    #1;
    tests++; if ({BUSY, MATCH_VALID, MATCH, MATCH_ADDR} !== 8'd0) begin fails++; $display("FAIL reset_outputs got %b exp 0", {BUSY, MATCH_VALID, MATCH, MATCH_ADDR}); end
    tick; tick;
    RESET = 0;
    tick;
    do_lookup(48'h0, v, m, a);
    tests++; if ({v, m, a} !== {1'b1, 1'b0, 5'd0}) begin fails++; $display("FAIL empty_lookup got v=%b m=%b a=%0d exp v=1 m=0 a=0", v, m, a); end
    tick;
    tests++; if (MATCH_VALID !== 1'b0) begin fails++; $display("FAIL valid_pulse got %b exp 0", MATCH_VALID); end
  endtask
  task automatic test_exact;
    logic v, m, b; logic [4:0] a;
    do_write(5'd3, K3, 48'h0, 1'b1, b);
    tests++; if (b !== 1'b1) begin fails++; $display("FAIL busy_after_we got %b exp 1", b); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL busy_clear got %b exp 0", BUSY); end
    do_lookup(K3, v, m, a);
    tests++; if ({v, m, a} !== {1'b1, 1'b1, 5'd3}) begin fails++; $display("FAIL exact_hit got v=%b m=%b a=%0d exp v=1 m=1 a=3", v, m, a); end
    do_lookup(48'h0A0B0C0D0E0E, v, m, a);
    tests++; if ({v, m, a} !== {1'b1, 1'b0, 5'd0}) begin fails++; $display("FAIL exact_miss got v=%b m=%b a=%0d exp v=1 m=0 a=0", v, m, a); end
  endtask
  task automatic test_priority;
    logic v, m, b; logic [4:0] a;
    do_write(5'd7, KM, 48'h0000000000FF, 1'b1, b);
    do_write(5'd2, KM, 48'h0000000000FF, 1'b1, b);
    do_lookup(48'h112233445555, v, m, a);
    tests++; if ({v, m, a} !== {1'b1, 1'b1, 5'd2}) begin fails++; $display("FAIL priority got v=%b m=%b a=%0d exp v=1 m=1 a=2", v, m, a); end
`ifdef TCAM_MULTI_MATCH_EN
    tests++; if (MULTIPLE_MATCH !== 1'b1) begin fails++; $display("FAIL multi_set got %b exp 1", MULTIPLE_MATCH); end
`endif
    tick;
    tests++; if ({MATCH_VALID, MATCH, MATCH_ADDR} !== {1'b0, 1'b1, 5'd2}) begin fails++; $display("FAIL hold got v=%b m=%b a=%0d exp v=0 m=1 a=2", MATCH_VALID, MATCH, MATCH_ADDR); end
  endtask
  task automatic test_invalidate_and_drop;
    logic v, m; logic [4:0] a;
    logic b;
    do_write(5'd2, 48'h0, 48'h0, 1'b0, b);
    do_lookup(48'h1122334455AA, v, m, a);
    tests++; if ({v, m, a} !== {1'b1, 1'b1, 5'd7}) begin fails++; $display("FAIL invalidate got v=%b m=%b a=%0d exp v=1 m=1 a=7", v, m, a); end
`ifdef TCAM_MULTI_MATCH_EN
    tests++; if (MULTIPLE_MATCH !== 1'b0) begin fails++; $display("FAIL multi_clear got %b exp 0", MULTIPLE_MATCH); end
`endif
    WE = 1; WR_ADDR = 5'd4; DIN = KX; DATA_MASK = 48'h0; WR_VALID = 1;
    tick;
    WR_ADDR = 5'd6; DIN = KY;
    tick;
    WE = 0;
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL drop_busy got %b exp 0", BUSY); end
    tick; tick;
    do_lookup(KY, v, m, a);
    tests++; if ({v, m, a} !== {1'b1, 1'b0, 5'd0}) begin fails++; $display("FAIL we_dropped got v=%b m=%b a=%0d exp v=1 m=0 a=0", v, m, a); end
    do_lookup(KX, v, m, a);
    tests++; if ({v, m, a} !== {1'b1, 1'b1, 5'd4}) begin fails++; $display("FAIL first_write got v=%b m=%b a=%0d exp v=1 m=1 a=4", v, m, a); end
  endtask
  task automatic test_back_to_back;
    logic [47:0] keys [8];
    logic exp_m [8];
    logic [4:0] exp_a [8];
    keys = '{K3, 48'h1, KM, KZ, KX, KY, K3, KZ};
    exp_m = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_a = '{5'd3, 5'd0, 5'd7, 5'd5, 5'd4, 5'd0, 5'd3, 5'd5};
    WE = 1; WR_ADDR = 5'd5; DIN = KZ; DATA_MASK = 48'h0; WR_VALID = 1;
    tick;
    WE = 0; CMP_REQ = 1; CMP_DIN = KZ;
    tick;
    tick;
    CMP_REQ = 0;
    tests++; if ({MATCH_VALID, MATCH, MATCH_ADDR} !== {1'b1, 1'b0, 5'd0}) begin fails++; $display("FAIL commit_old got v=%b m=%b a=%0d exp v=1 m=0 a=0", MATCH_VALID, MATCH, MATCH_ADDR); end
    tick;
    tests++; if ({MATCH_VALID, MATCH, MATCH_ADDR} !== {1'b1, 1'b1, 5'd5}) begin fails++; $display("FAIL after_commit got v=%b m=%b a=%0d exp v=1 m=1 a=5", MATCH_VALID, MATCH, MATCH_ADDR); end
    tick;
    for (int k = 0; k <= 8; k++) begin
      CMP_REQ = (k < 8);
      if (k < 8) CMP_DIN = keys[k];
      tick;
      if (k >= 1) begin
        tests++; if ({MATCH_VALID, MATCH, MATCH_ADDR} !== {1'b1, exp_m[k-1], exp_a[k-1]}) begin fails++; $display("FAIL b2b_%0d got v=%b m=%b a=%0d exp v=1 m=%b a=%0d", k-1, MATCH_VALID, MATCH, MATCH_ADDR, exp_m[k-1], exp_a[k-1]); end
      end
    end
    CMP_REQ = 0;
    tick;
    tests++; if (MATCH_VALID !== 1'b0) begin fails++; $display("FAIL b2b_end got %b exp 0", MATCH_VALID); end
  endtask
  task automatic test_reset_mid_write;
    logic v, m; logic [4:0] a;
    int seen = 0;
    CMP_REQ = 1; CMP_DIN = K3;
    WE = 1; WR_ADDR = 5'd6; DIN = KW; DATA_MASK = 48'h0; WR_VALID = 1;
    tick;
    WE = 0;
    tick;
    CMP_REQ = 0;
    #2 RESET = 1;
    #1;
    tests++; if ({BUSY, MATCH_VALID} !== 2'b00) begin fails++; $display("FAIL rst_mid got busy=%b v=%b exp 0 0", BUSY, MATCH_VALID); end
    tick;
    RESET = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (MATCH_VALID) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rst_flush got %0d pulses exp 0", seen); end
    do_lookup(KW, v, m, a);
    tests++; if ({v, m, a} !== {1'b1, 1'b0, 5'd0}) begin fails++; $display("FAIL rst_write_lost got v=%b m=%b a=%0d exp v=1 m=0 a=0", v, m, a); end
    do_lookup(K3, v, m, a);
    tests++; if ({v, m, a} !== {1'b1, 1'b0, 5'd0}) begin fails++; $display("FAIL rst_cleared got v=%b m=%b a=%0d exp v=1 m=0 a=0", v, m, a); end
  endtask
  initial begin
    RESET = 0; WE = 0; WR_ADDR = 0; DIN = 0; DATA_MASK = 0; WR_VALID = 0; CMP_REQ = 0; CMP_DIN = 0;
    #2;
    test_reset;
    test_exact;
    test_priority;
    test_invalidate_and_drop;
    test_back_to_back;
    test_reset_mid_write;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
